crank_pattern_gen: RTL and testbench
====================================

CRANK_PATTERN_GEN -- requirements
Module: crank_pattern_gen

Interface
REQ-001 Parameter WIDTH, default 16: width of the tooth period and phase counters.
REQ-002 Parameter TEETH, default 60: tooth positions per revolution, including missing teeth.
REQ-003 Parameter GAP, default 2: missing teeth per revolution; legal range 1..TEETH-2.
REQ-004 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1: asynchronous, active-high reset.
REQ-006 Port ena, input, 1: run enable; 0 forces IDLE.
REQ-007 Port sel, input, 1: output polarity; 0 = active level high (rising active edge), 1 = active level low (falling active edge).
REQ-008 Port period, input, WIDTH: clocks per tooth position.
REQ-009 Port q, output, 1: generated crank-wheel pin signal, registered.
REQ-010 Port tooth_strobe, output, 1: one-cycle pulse in the first cycle of each tooth's active phase.
REQ-011 Port gap_strobe, output, 1: one-cycle pulse in the first cycle of the gap.
REQ-012 Port tooth_num, output, 8: index of current or last-emitted tooth, 0..TEETH-GAP-1.
REQ-013 Port busy, output, 1: high in every state except IDLE.

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, ACT, INACT, GAP.
REQ-015 Effective period P SHALL be max(period, 2); active phase length H = P>>1; inactive phase length L = P-H.
REQ-016 P SHALL be latched at tooth start (entry to ACT) and at entry to each gap period; mid-phase changes to period SHALL have no effect until the next latch point.
REQ-017 sel SHALL be latched only in IDLE; changes while busy SHALL be ignored until the next return to IDLE.
REQ-018 IDLE: q at inactive level of the latched sel; tooth_num = 0; on clock edge with ena=1, go to ACT with tooth_num = 0.
REQ-019 ACT: q at active level for exactly H clocks; tooth_strobe asserted in the first ACT cycle only; then go to INACT.
REQ-020 INACT: q at inactive level for exactly L clocks; then go to ACT with tooth_num+1 if tooth_num < TEETH-GAP-1, else go to GAP.
REQ-021 GAP: q at inactive level for exactly GAP*P clocks, counted as GAP sub-periods of P with P re-latched per sub-period; gap_strobe in the first GAP cycle; tooth_num holds TEETH-GAP-1.
REQ-022 On GAP expiry with ena=1, go to ACT with tooth_num = 0 (wrap); no idle cycle is inserted.
REQ-023 ena=0 sampled in any state SHALL force IDLE on that edge: q inactive and tooth_num = 0 on the next cycle, with no strobes.
REQ-024 Latency: q SHALL first reach the active level in the cycle after the edge that samples ena=1 in IDLE.
REQ-025 q, tooth_strobe, gap_strobe, tooth_num and busy SHALL all be registered outputs; no combinational path from any input to any output.
REQ-026 Phase counters SHALL be WIDTH bits and SHALL never wrap within a phase. The gap sub-period counter SHALL be ceil(log2(GAP+1)) bits.
REQ-027 tooth_strobe and gap_strobe SHALL never be asserted in the same cycle.

Reset
REQ-028 While rst=1 the block SHALL be in IDLE with latched sel = 0, q = 0, tooth_strobe = 0, gap_strobe = 0, tooth_num = 0, busy = 0, and all counters at 0, regardless of clk.
REQ-029 Reset asserted mid-tooth or mid-gap SHALL take effect immediately (asynchronously). After release, the first ena=1 edge SHALL start again at tooth 0.

Verification
REQ-030 Nominal pattern. Stimulus: TEETH=6, GAP=2, sel=0, period=4, ena held at 1. Response: q = 1100 repeated 4 times, then 8 zeros, repeating. tooth_strobe fires 4 times per revolution; gap_strobe fires once, 16 clocks after the first tooth_strobe.
REQ-031 Polarity and odd period. Stimulus: sel=1, period=5. Response: each tooth is q=0 for 2 clocks then q=1 for 3 clocks; the gap is q=1 for 10 clocks.
REQ-032 Minimum clamp. Stimulus: period=0, then period=1. Response: both behave as P=2, giving q = 10 per tooth and a 4-clock gap for GAP=2.
REQ-033 Period change mid-tooth. Stimulus: period changes 4 to 8 during the ACT of tooth 1. Response: tooth 1 keeps 2+2 clocks; tooth 2 is 4+4 clocks.
REQ-034 Disable mid-operation. Stimulus: ena drops during the gap. Response: busy=0, q inactive and tooth_num=0 on the next cycle; no gap_strobe follows. Re-enable restarts at tooth 0 with 1-cycle latency.
REQ-035 Asynchronous reset. Stimulus: rst pulsed between clk edges during ACT. Response: q=0 and busy=0 immediately, before the next clk edge; after release, operation is identical to a cold start.

Source files
------------

// File: rtl/crank_pattern_gen.sv
// Purpose: crank-wheel pin pattern generator (TEETH positions, GAP missing teeth per revolution).
// Latency: q reaches the active level one cycle after the edge that samples ena=1 in IDLE.
// Backpressure: none; ena=0 returns to IDLE on the sampling edge, all outputs registered.
module crank_pattern_gen #(
  parameter int WIDTH = 16,
  parameter int TEETH = 60,
  parameter int GAP   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             sel,
  input  logic [WIDTH-1:0] period,
  output logic             q,
  output logic             tooth_strobe,
  output logic             gap_strobe,
  output logic [7:0]       tooth_num,
  output logic             busy
);

  localparam int SUBW = $clog2(GAP + 1);
  localparam logic [7:0]       LAST_TOOTH = 8'(TEETH - GAP - 1);
  localparam logic [SUBW-1:0]  SUB_INIT   = SUBW'(GAP - 1);
  localparam logic [SUBW-1:0]  SUB_ONE    = SUBW'(1);
  localparam logic [WIDTH-1:0] CNT_ONE    = WIDTH'(1);
  localparam logic [WIDTH-1:0] P_MIN      = WIDTH'(2);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACT   = 2'd1,
    S_INACT = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;     // remaining clocks in phase, minus one
  logic [WIDTH-1:0] p_q, p_d;         // effective period latched at the last latch point
  logic [SUBW-1:0]  sub_q, sub_d;     // remaining gap sub-periods, minus one
  logic             sel_q, sel_d;
  logic             q_q, q_d;
  logic             ts_q, ts_d;
  logic             gs_q, gs_d;
  logic [7:0]       tn_q, tn_d;
  logic             busy_q, busy_d;

  logic [WIDTH-1:0] p_eff;   // period clamped to the minimum of 2
  logic [WIDTH-1:0] h_new;   // active length from the period being latched now
  logic [WIDTH-1:0] l_cur;   // inactive length from the period latched at tooth start

  // Clamp the incoming period and derive phase lengths.
  always_comb begin
    p_eff = (period < P_MIN) ? P_MIN : period;
    h_new = p_eff >> 1;
    l_cur = p_q - (p_q >> 1);
  end

  // Next-state, counter and registered-output computation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    sub_d   = sub_q;
    sel_d   = sel_q;
    tn_d    = tn_q;

    // Polarity only follows the input while idle, including the edge that leaves IDLE.
    if (state_q == S_IDLE) begin
      sel_d = sel;
    end

    if (!ena) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      sub_d   = '0;
      tn_d    = 8'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_ACT;
          p_d     = p_eff;
          cnt_d   = h_new - CNT_ONE;
          tn_d    = 8'd0;
        end
        S_ACT: begin
          if (cnt_q == '0) begin
            state_d = S_INACT;
            cnt_d   = l_cur - CNT_ONE;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        S_INACT: begin
          if (cnt_q == '0) begin
            p_d = p_eff;
            if (tn_q < LAST_TOOTH) begin
              state_d = S_ACT;
              tn_d    = tn_q + 8'd1;
              cnt_d   = h_new - CNT_ONE;
            end else begin
              state_d = S_GAP;
              cnt_d   = p_eff - CNT_ONE;
              sub_d   = SUB_INIT;
            end
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        S_GAP: begin
          if (cnt_q == '0) begin
            p_d = p_eff;
            if (sub_q == '0) begin
              state_d = S_ACT;
              tn_d    = 8'd0;
              cnt_d   = h_new - CNT_ONE;
            end else begin
              sub_d = sub_q - SUB_ONE;
              cnt_d = p_eff - CNT_ONE;
            end
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    // Strobes mark entry into ACT/GAP; the two states never coincide so strobes are exclusive.
    q_d    = (state_d == S_ACT) ? ~sel_d : sel_d;
    ts_d   = (state_d == S_ACT) && (state_q != S_ACT);
    gs_d   = (state_d == S_GAP) && (state_q != S_GAP);
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with asynchronous reset to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      p_q     <= '0;
      sub_q   <= '0;
      sel_q   <= 1'b0;
      q_q     <= 1'b0;
      ts_q    <= 1'b0;
      gs_q    <= 1'b0;
      tn_q    <= 8'd0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      sub_q   <= sub_d;
      sel_q   <= sel_d;
      q_q     <= q_d;
      ts_q    <= ts_d;
      gs_q    <= gs_d;
      tn_q    <= tn_d;
      busy_q  <= busy_d;
    end
  end

  assign q            = q_q;
  assign tooth_strobe = ts_q;
  assign gap_strobe   = gs_q;
  assign tooth_num    = tn_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_crank_pattern_gen.sv
// Purpose: directed self-checking bench for crank_pattern_gen with TEETH=6, GAP=2.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: none; all waits are single clock edges.
module tb_crank_pattern_gen;

  logic        clk;
  logic        rst;
  logic        ena;
  logic        sel;
  logic [15:0] period;
  logic        q;
  logic        tooth_strobe;
  logic        gap_strobe;
  logic [7:0]  tooth_num;
  logic        busy;

  int tests = 0;
  int fails = 0;

  crank_pattern_gen #(.WIDTH(16), .TEETH(6), .GAP(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .ena          (ena),
    .sel          (sel),
    .period       (period),
    .q            (q),
    .tooth_strobe (tooth_strobe),
    .gap_strobe   (gap_strobe),
    .tooth_num    (tooth_num),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic eq, input logic ets, input logic egs,
                         input logic [7:0] etn, input logic eb);
    chk({tag, ".q"}, {7'd0, q}, {7'd0, eq});
    chk({tag, ".tooth_strobe"}, {7'd0, tooth_strobe}, {7'd0, ets});
    chk({tag, ".gap_strobe"}, {7'd0, gap_strobe}, {7'd0, egs});
    chk({tag, ".tooth_num"}, tooth_num, etn);
    chk({tag, ".busy"}, {7'd0, busy}, {7'd0, eb});
  endtask

  // Advance one clock and check every output.
  task automatic cyc(input string tag, input logic eq, input logic ets, input logic egs,
                     input logic [7:0] etn, input logic eb);
    @(posedge clk);
    #1;
    chk_all(tag, eq, ets, egs, etn, eb);
  endtask

  // One tooth: h clocks at the active level act, then l clocks at ~act.
  task automatic tooth(input string tag, input logic [7:0] n, input int h, input int l,
                       input logic act);
    for (int i = 0; i < h; i++) cyc(tag, act, (i == 0), 1'b0, n, 1'b1);
    for (int i = 0; i < l; i++) cyc(tag, ~act, 1'b0, 1'b0, n, 1'b1);
  endtask

  task automatic gap(input string tag, input int len, input logic inact);
    for (int i = 0; i < len; i++) cyc(tag, inact, 1'b0, (i == 0), 8'd3, 1'b1);
  endtask

  initial begin
    rst = 1'b1; ena = 1'b0; sel = 1'b0; period = 16'd4;

    // Reset state before any clock edge, and held across an edge.
    #3;
    chk_all("rst_async", 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    @(posedge clk); #1;
    chk_all("rst_hold", 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    rst = 1'b0;
    cyc("idle", 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);

    // Nominal: period 4 -> 1100 per tooth, 8-clock gap, then wrap to tooth 0 with no idle.
    ena = 1'b1;
    for (int t = 0; t < 4; t++) tooth("nom", 8'(t), 2, 2, 1'b1);
    gap("nom_gap", 8, 1'b0);
    tooth("nom_wrap", 8'd0, 2, 2, 1'b1);

    // Disable during the gap: straight to IDLE, no further gap strobe.
    for (int t = 1; t < 4; t++) tooth("dis", 8'(t), 2, 2, 1'b1);
    for (int i = 0; i < 3; i++) cyc("dis_gap", 1'b0, 1'b0, (i == 0), 8'd3, 1'b1);
    ena = 1'b0;
    cyc("dis_idle", 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    for (int i = 0; i < 6; i++) cyc("dis_hold", 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    ena = 1'b1;
    tooth("reen", 8'd0, 2, 2, 1'b1);

    // Period change during ACT of tooth 1: tooth 1 stays 2+2, tooth 2 becomes 4+4.
    cyc("pchg_t1", 1'b1, 1'b1, 1'b0, 8'd1, 1'b1);
    period = 16'd8;
    cyc("pchg_t1", 1'b1, 1'b0, 1'b0, 8'd1, 1'b1);
    cyc("pchg_t1", 1'b0, 1'b0, 1'b0, 8'd1, 1'b1);
    cyc("pchg_t1", 1'b0, 1'b0, 1'b0, 8'd1, 1'b1);
    tooth("pchg_t2", 8'd2, 4, 4, 1'b1);
    ena = 1'b0;
    cyc("pchg_idle", 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);

    // Inverted polarity, odd period 5: active low 2 clocks, high 3, gap high 10.
    sel = 1'b1; period = 16'd5;
    cyc("pol_idle", 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
    ena = 1'b1;
    tooth("pol", 8'd0, 2, 3, 1'b0);
    sel = 1'b0;  // ignored while busy
    for (int t = 1; t < 4; t++) tooth("pol", 8'(t), 2, 3, 1'b0);
    gap("pol_gap", 10, 1'b1);
    tooth("pol_wrap", 8'd0, 2, 3, 1'b0);
    ena = 1'b0;
    cyc("pol_idle1", 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
    cyc("pol_idle2", 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);

    // Minimum clamp: period 0 and period 1 both behave as P=2.
    period = 16'd0; ena = 1'b1;
    for (int t = 0; t < 4; t++) tooth("clamp0", 8'(t), 1, 1, 1'b1);
    period = 16'd1;
    gap("clamp_gap0", 4, 1'b0);
    for (int t = 0; t < 4; t++) tooth("clamp1", 8'(t), 1, 1, 1'b1);
    gap("clamp_gap1", 4, 1'b0);
    ena = 1'b0;
    cyc("clamp_idle", 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);

    // Asynchronous reset mid-tooth, then a cold start.
    period = 16'd4; ena = 1'b1;
    tooth("ar_pre", 8'd0, 2, 2, 1'b1);
    cyc("ar_pre_t1", 1'b1, 1'b1, 1'b0, 8'd1, 1'b1);
    #3; rst = 1'b1;
    #1;
    chk_all("ar_now", 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    @(posedge clk); #1;
    chk_all("ar_held", 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    #3; rst = 1'b0;
    tooth("ar_cold", 8'd0, 2, 2, 1'b1);
    tooth("ar_cold", 8'd1, 2, 2, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
